// File: rtl/lms_plant_source_pkg.sv
// Shared definitions for the LMS plant source and the adaptive filter it drives.
// Widths, fixed-point scaling, LFSR seed/taps and the sample FSM states.
package lms_plant_source_pkg;

    localparam int          L_TAPS   = 16;
    localparam int          XW       = 12;
    localparam int          DW       = 14;
    localparam int          CW       = 16;
    localparam int          ACCW     = 32;
    localparam int          FRAC     = 12;
    localparam logic [15:0] SEED     = 16'hACE1;
    // Feedback taps: bits 0, 2, 3 and 5.
    localparam logic [15:0] TAP_MASK = 16'h002D;

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/lms_plant_source_lfsr16.sv
// 16-bit right-shifting LFSR; advances one step per cycle while step is high.
module lfsr16 #(
    parameter logic [15:0] SEED = lms_plant_source_pkg::SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);
    import lms_plant_source_pkg::*;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/lms_plant_source.sv
// Plant source for LMS system identification: pseudo-noise x and d = FIR(x) >>> FRAC + noise.
// Coefficients are written to a shadow bank and copied to the active bank at a sample start.
module lms_plant_source #(
    parameter int          L    = lms_plant_source_pkg::L_TAPS,
    parameter int          XW   = lms_plant_source_pkg::XW,
    parameter int          DW   = lms_plant_source_pkg::DW,
    parameter int          CW   = lms_plant_source_pkg::CW,
    parameter logic [15:0] SEED = lms_plant_source_pkg::SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           div_in,
    input  logic [2:0]           noise_sh,
    input  logic                 coef_wr,
    input  logic [$clog2(L)-1:0] coef_addr,
    input  logic [CW-1:0]        coef_data,
    input  logic                 coef_commit,
    output logic [XW-1:0]        x_out,
    output logic [DW-1:0]        d_out,
    output logic                 valid_out,
    output logic                 busy
);
    import lms_plant_source_pkg::*;

    localparam int                    AW       = $clog2(L);
    localparam int                    SW       = 21;
    localparam logic [7:0]            P_MIN_M1 = 8'(L + 3);
    localparam logic signed [SW-1:0]  D_MAX    = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0]  D_MIN    = SW'(-(2 ** (DW - 1)));

    state_t                   state, state_next;
    logic [7:0]               counter;
    logic [7:0]               period_m1;
    logic                     tick;
    logic [15:0]              lfsr;
    logic signed [XW-1:0]     hist   [L];
    logic signed [CW-1:0]     shadow [L];
    logic signed [CW-1:0]     active [L];
    logic signed [ACCW-1:0]   acc;
    logic [AW-1:0]            idx;
    logic                     commit_pending;
    logic signed [XW+CW-1:0]  prod;
    logic signed [SW-1:0]     acc_sh, noise_base, noise, s_sum;
    logic [DW-1:0]            d_sat;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (state == SHIFT),
        .value (lfsr)
    );

    // Period is clamped so a new tick can never land while a sample is in flight.
    assign period_m1 = (div_in > P_MIN_M1) ? div_in : P_MIN_M1;
    assign tick      = enable && (counter == 8'd0);
    assign busy      = (state != IDLE);
    assign prod      = hist[idx] * active[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= 8'd0;
        end else if (enable) begin
            counter <= (counter == 8'd0) ? period_m1 : counter - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = SHIFT;
            SHIFT:   state_next = MAC;
            MAC:     if (idx == AW'(L - 1)) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_sh     = SW'(acc >>> FRAC);
        noise_base = SW'($signed(lfsr[3:0]));
        noise      = '0;
        if (noise_sh != 3'd0) begin
            noise = noise_base <<< (noise_sh - 3'd1);
        end
        s_sum = acc_sh + noise;
        if (s_sum > D_MAX) begin
            d_sat = DW'(D_MAX);
        end else if (s_sum < D_MIN) begin
            d_sat = DW'(D_MIN);
        end else begin
            d_sat = DW'(s_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                hist[k]   <= '0;
                shadow[k] <= (k == 0) ? CW'(1 << FRAC) : '0;
                active[k] <= (k == 0) ? CW'(1 << FRAC) : '0;
            end
            acc            <= '0;
            idx            <= '0;
            commit_pending <= 1'b0;
            x_out          <= '0;
            d_out          <= '0;
            valid_out      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (coef_wr) begin
                shadow[coef_addr] <= coef_data;
            end
            if (coef_commit) begin
                commit_pending <= 1'b1;
            end
            case (state)
                SHIFT: begin
                    hist[0] <= XW'(lfsr_step(lfsr) >> (16 - XW));
                    for (int k = 1; k < L; k++) begin
                        hist[k] <= hist[k-1];
                    end
                    acc <= '0;
                    idx <= '0;
                    // A commit arriving in this very cycle stays pending for the next sample.
                    if (commit_pending) begin
                        for (int k = 0; k < L; k++) begin
                            active[k] <= shadow[k];
                        end
                        commit_pending <= coef_commit;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    idx <= idx + AW'(1);
                end
                OUT: begin
                    x_out     <= hist[0];
                    d_out     <= d_sat;
                    valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_plant_source.sv
// Directed bench for lms_plant_source: vector table of single-sample results plus
// hand-written sequences for timing, coefficient swap and reset corner cases.
module tb_lms_plant_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  div_in;
    logic [2:0]  noise_sh;
    logic        coef_wr;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        coef_commit;
    logic [11:0] x_out;
    logic [13:0] d_out;
    logic        valid_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0] exp_q[$];

    typedef struct {
        logic [15:0] h0;
        logic [2:0]  nsh;
        int          sample;
        int          exp_x;
        int          exp_d;
    } vec_t;

    vec_t vecs[12];

    lms_plant_source dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div_in      (div_in),
        .noise_sh    (noise_sh),
        .coef_wr     (coef_wr),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .x_out       (x_out),
        .d_out       (d_out),
        .valid_out   (valid_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        div_in      = 8'd0;
        noise_sh    = 3'd0;
        coef_wr     = 1'b0;
        coef_addr   = 4'd0;
        coef_data   = 16'd0;
        coef_commit = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic drive_coef(input logic wr, input logic [3:0] addr,
                              input logic [15:0] data, input logic commit);
        coef_wr     = wr;
        coef_addr   = addr;
        coef_data   = data;
        coef_commit = commit;
        step(1);
        coef_wr     = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output logic got);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            step(1);
            cycles++;
            if (valid_out) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: no valid_out within %0d cycles", budget);
        end
    endtask

    task automatic wait_busy(input int budget);
        int c;
        c = 0;
        while (!busy && c < budget) begin
            step(1);
            c++;
        end
        if (!busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: busy not seen within %0d cycles", budget);
        end
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (valid_out) cnt++;
        end
    endtask

    function automatic logic [11:0] model_x(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end
        return s[15:4];
    endfunction

    initial begin
        int          cyc;
        int          cnt;
        logic        got;
        logic [25:0] e;
        int          div_tab [5];
        int          sp_tab  [5];

        vecs[0]  = '{16'h1000, 3'd0, 1,  1383,  1383};
        vecs[1]  = '{16'h7FFF, 3'd0, 1,  1383,  8191};
        vecs[2]  = '{16'h8000, 3'd0, 1,  1383, -8192};
        vecs[3]  = '{16'h0800, 3'd0, 1,  1383,   691};
        vecs[4]  = '{16'hF000, 3'd0, 1,  1383, -1383};
        vecs[5]  = '{16'h0800, 3'd0, 2, -1357,  -679};
        vecs[6]  = '{16'h1000, 3'd1, 2, -1357, -1365};
        vecs[7]  = '{16'h1000, 3'd3, 2, -1357, -1389};
        vecs[8]  = '{16'h1000, 3'd7, 2, -1357, -1869};
        vecs[9]  = '{16'h1000, 3'd2, 3,  1369,  1361};
        vecs[10] = '{16'h7FFF, 3'd0, 2, -1357, -8192};
        vecs[11] = '{16'h1000, 3'd7, 1,  1383,  1383};

        div_tab = '{3, 16, 19, 20, 99};
        sp_tab  = '{20, 20, 20, 21, 100};

        // Reset state, first-sample latency, spacing and pulse width.
        do_reset();
        check("reset_x", $signed(x_out), 0);
        check("reset_d", $signed(d_out), 0);
        check("reset_valid", valid_out, 0);
        check("reset_busy", busy, 0);
        enable = 1'b1;
        wait_valid(300, cyc, got);
        check("first_latency", cyc, 19);
        check("first_x", $signed(x_out), 1383);
        check("first_d", $signed(d_out), 1383);
        wait_valid(300, cyc, got);
        check("spacing_div0", cyc, 20);
        step(1);
        check("valid_pulse_width", valid_out, 0);
        check("x_held", $signed(x_out), -1357);

        // Table of single-sample results from reset.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            noise_sh = vecs[v].nsh;
            drive_coef(1'b1, 4'd0, vecs[v].h0, 1'b1);
            enable = 1'b1;
            for (int s = 0; s < vecs[v].sample; s++) begin
                wait_valid(300, cyc, got);
            end
            check($sformatf("vec%0d_x", v), $signed(x_out), vecs[v].exp_x);
            check($sformatf("vec%0d_d", v), $signed(d_out), vecs[v].exp_d);
        end

        // Pure 3-sample delay plant: d_n = x_(n-3).
        do_reset();
        drive_coef(1'b1, 4'd0, 16'h0000, 1'b0);
        drive_coef(1'b1, 4'd3, 16'h1000, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            exp_q.push_back({model_x(n), (n > 3) ? 14'($signed(model_x(n - 3))) : 14'd0});
        end
        enable = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            wait_valid(300, cyc, got);
            e = exp_q.pop_front();
            check($sformatf("delay3_x%0d", n), $signed(x_out), $signed(e[25:14]));
            check($sformatf("delay3_d%0d", n), $signed(d_out), $signed(e[13:0]));
        end

        // Commit timing: during MAC, exactly in SHIFT, and a write in SHIFT.
        do_reset();
        enable = 1'b1;
        wait_busy(100);
        step(3);
        drive_coef(1'b1, 4'd0, 16'h0800, 1'b1);
        wait_valid(300, cyc, got);
        check("mac_commit_old", $signed(d_out), 1383);
        wait_busy(100);
        wait_valid(300, cyc, got);
        check("mac_commit_new", $signed(d_out), -679);
        wait_busy(100);
        drive_coef(1'b1, 4'd0, 16'hF000, 1'b1);
        wait_valid(300, cyc, got);
        check("shift_commit_deferred", $signed(d_out), 684);
        wait_busy(100);
        step(3);
        drive_coef(1'b1, 4'd0, 16'h1000, 1'b1);
        wait_valid(300, cyc, got);
        check("shift_commit_applied", $signed(d_out), -684);
        wait_busy(100);
        drive_coef(1'b1, 4'd0, 16'h0000, 1'b0);
        wait_valid(300, cyc, got);
        check("shift_write_pre_value", $signed(d_out), 342);
        wait_busy(100);
        wait_valid(300, cyc, got);
        check("shift_write_not_copied", $signed(d_out), -1877);

        // Sample period clamp and division.
        do_reset();
        enable = 1'b1;
        wait_valid(300, cyc, got);
        for (int i = 0; i < 5; i++) begin
            div_in = 8'(div_tab[i]);
            wait_valid(300, cyc, got);
            wait_valid(300, cyc, got);
            check($sformatf("spacing_div%0d", div_tab[i]), cyc, sp_tab[i]);
        end

        // Dropping enable mid-MAC lets that sample finish, then stops.
        do_reset();
        enable = 1'b1;
        wait_busy(100);
        step(3);
        enable = 1'b0;
        wait_valid(300, cyc, got);
        check("disable_sample_done", got, 1);
        check("disable_sample_x", $signed(x_out), 1383);
        count_valid(300, cnt);
        check("disable_no_more_valid", cnt, 0);

        // Reset in MAC at idx 7 of the second sample.
        do_reset();
        enable = 1'b1;
        wait_valid(300, cyc, got);
        wait_busy(100);
        step(8);
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        enable = 1'b0;
        check("midreset_x", $signed(x_out), 0);
        check("midreset_d", $signed(d_out), 0);
        check("midreset_busy", busy, 0);
        count_valid(40, cnt);
        check("midreset_no_valid", cnt, 0);
        enable = 1'b1;
        wait_valid(300, cyc, got);
        check("midreset_reseed_x", $signed(x_out), 1383);
        check("midreset_reseed_d", $signed(d_out), 1383);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
